// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared widths, tag-entry bit positions and controller states
//                for the 2-way set-associative data-cache controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  localparam int TAG_W    = 23;
  localparam int INDEX_W  = 4;
  localparam int LINE_W   = 256;
  localparam int WORD_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int SEL_W    = 3;
  localparam int WORDS    = LINE_W / WORD_W;

  // Tag entry layout: {valid, dirty, tag}
  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;
  localparam int ENTRY_W   = TAG_W + 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    READMISS   = 3'd3,
    READMISSOK = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_if
//  Description : CPU, memory and tag/data-array signals of the data-cache
//                controller. The master side is the environment (CPU, memory,
//                array); the slave side is the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcache_if;
  import dcache_pkg::*;

  // CPU MEM stage
  logic [31:0]         cpu_addr_i;
  logic [WORD_W-1:0]   cpu_data_i;
  logic                cpu_MemRead_i;
  logic                cpu_MemWrite_i;
  logic [WORD_W-1:0]   cpu_data_o;
  logic                cpu_stall_o;

  // Backing memory
  logic [31:0]         mem_addr_o;
  logic [LINE_W-1:0]   mem_data_o;
  logic                mem_enable_o;
  logic                mem_write_o;
  logic [LINE_W-1:0]   mem_data_i;
  logic                mem_ack_i;

  // Tag/data array
  logic [INDEX_W-1:0]  sram_index_o;
  logic [ENTRY_W-1:0]  sram_tag_o;
  logic [LINE_W-1:0]   sram_data_o;
  logic                sram_enable_o;
  logic                sram_write_o;
  logic [ENTRY_W-1:0]  sram_tag_i;
  logic [LINE_W-1:0]   sram_data_i;
  logic                sram_hit_i;

  modport master (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    input  cpu_data_o, cpu_stall_o,
    input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    output mem_data_i, mem_ack_i,
    input  sram_index_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    output sram_tag_i, sram_data_i, sram_hit_i
  );

  modport slave (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    output cpu_data_o, cpu_stall_o,
    output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    input  mem_data_i, mem_ack_i,
    output sram_index_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    input  sram_tag_i, sram_data_i, sram_hit_i
  );

endinterface
`default_nettype wire

// File: rtl/dcache_word_merge.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_word_merge
//  Description : Combinational word access on a cache line: extracts the
//                selected 32-bit word and builds the line with that word
//                replaced by new store data.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_word_merge
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] line,
  input  logic [WORD_W-1:0] word,
  input  logic [SEL_W-1:0]  sel,
  output logic [LINE_W-1:0] merged,
  output logic [WORD_W-1:0] extracted
);

  // Word offset inside the line, in bits
  logic [SEL_W+OFFSET_W-1:0] bit_base;
  assign bit_base  = {sel, {OFFSET_W{1'b0}}};
  assign extracted = line[bit_base +: WORD_W];

  for (genvar k = 0; k < WORDS; k++) begin : g_word
    assign merged[k*WORD_W +: WORD_W] =
      (sel == SEL_W'(k)) ? word : line[k*WORD_W +: WORD_W];
  end

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_controller
//  Description : Data-cache controller between the CPU MEM stage and a 2-way
//                set-associative tag/data array. Hits resolve in the cycle of
//                the request; misses stall the CPU, write back a dirty
//                victim, refill the line and let the held request replay.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller
  import dcache_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.slave  bus
);

  state_t              state;
  logic [31:0]         req_addr;
  logic [WORD_W-1:0]   req_data;
  logic                req_write;
  logic [TAG_W-1:0]    wb_tag;
  logic [LINE_W-1:0]   wb_line;
  logic [LINE_W-1:0]   refill_line;
  logic                mem_en;

  logic                is_idle;
  logic                rd_req;
  logic                wr_req;
  logic                any_req;
  logic                write_hit;
  logic                miss;
  logic                victim_dirty;
  logic [31:0]         cur_addr;
  logic [TAG_W-1:0]    cur_tag;
  logic [INDEX_W-1:0]  cur_index;
  logic [SEL_W-1:0]    cur_sel;
  logic [LINE_W-1:0]   merged_line;
  logic [WORD_W-1:0]   sel_word;

  // Store wins when both request strobes are asserted
  assign wr_req  = bus.cpu_MemWrite_i;
  assign rd_req  = bus.cpu_MemRead_i & ~bus.cpu_MemWrite_i;
  assign any_req = rd_req | wr_req;
  assign is_idle = (state == IDLE);

  // Live CPU address while idle; the latched request during the whole miss
  assign cur_addr  = is_idle ? bus.cpu_addr_i : req_addr;
  assign cur_tag   = cur_addr[31:INDEX_W+OFFSET_W];
  assign cur_index = cur_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign cur_sel   = cur_addr[OFFSET_W-1:2];

  assign write_hit    = is_idle & wr_req & bus.sram_hit_i;
  assign miss         = is_idle & any_req & ~bus.sram_hit_i;
  assign victim_dirty = bus.sram_tag_i[VALID_BIT] & bus.sram_tag_i[DIRTY_BIT];

  dcache_word_merge u_merge (
    .line      (bus.sram_data_i),
    .word      (bus.cpu_data_i),
    .sel       (cur_sel),
    .merged    (merged_line),
    .extracted (sel_word)
  );

  // Latched store data/flag are kept for observability of the held request;
  // the replay itself uses the CPU's held inputs.
  logic unused_bits;
  assign unused_bits = &{1'b0, req_data, req_write, cur_addr[1:0]};

  // CPU and array side outputs, decoded from state and the hit lookup
  always_comb begin
    bus.cpu_data_o    = sel_word;
    bus.cpu_stall_o   = ~is_idle | miss;
    bus.sram_index_o  = cur_index;
    bus.sram_enable_o = is_idle ? any_req : 1'b1;
    bus.sram_write_o  = write_hit | (state == READMISSOK);
    bus.sram_tag_o    = {2'b00, cur_tag};
    bus.sram_data_o   = '0;
    if (write_hit) begin
      bus.sram_tag_o  = {2'b11, cur_tag};
      bus.sram_data_o = merged_line;
    end else if (state == READMISSOK) begin
      bus.sram_tag_o  = {2'b10, cur_tag};
      bus.sram_data_o = refill_line;
    end
  end

  // Memory side outputs: victim address/line during write-back, refill
  // address during the read
  always_comb begin
    bus.mem_enable_o = mem_en;
    bus.mem_write_o  = mem_en & (state == WRITEBACK);
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;
    if (state == WRITEBACK) begin
      bus.mem_addr_o = {wb_tag, cur_index, {OFFSET_W{1'b0}}};
      bus.mem_data_o = wb_line;
    end else if (state == READMISS) begin
      bus.mem_addr_o = {cur_tag, cur_index, {OFFSET_W{1'b0}}};
    end
  end

  // Miss-handling FSM; mem_en is its registered memory-request output and
  // drops the cycle after every ack so each memory transaction is distinct
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_addr    <= '0;
      req_data    <= '0;
      req_write   <= 1'b0;
      wb_tag      <= '0;
      wb_line     <= '0;
      refill_line <= '0;
      mem_en      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_en <= 1'b0;
          if (miss) begin
            req_addr  <= bus.cpu_addr_i;
            req_data  <= bus.cpu_data_i;
            req_write <= wr_req;
            state     <= MISS;
          end
        end
        MISS: begin
          mem_en <= 1'b1;
          if (victim_dirty) begin
            wb_tag  <= bus.sram_tag_i[TAG_W-1:0];
            wb_line <= bus.sram_data_i;
            state   <= WRITEBACK;
          end else begin
            state <= READMISS;
          end
        end
        WRITEBACK: begin
          if (mem_en && bus.mem_ack_i) begin
            mem_en <= 1'b0;
            state  <= READMISS;
          end
        end
        READMISS: begin
          if (mem_en && bus.mem_ack_i) begin
            refill_line <= bus.mem_data_i;
            mem_en      <= 1'b0;
            state       <= READMISSOK;
          end else begin
            mem_en <= 1'b1;
          end
        end
        READMISSOK: begin
          state <= IDLE;
        end
        default: begin
          mem_en <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_controller
//  Description : Self-checking bench for dcache_controller with a behavioural
//                2-way LRU array, a latency-programmable memory and a flat
//                word-memory reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_controller;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_if bus ();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural tag/data array ----------------
  logic [24:0]  tag_mem  [16][2];
  logic [255:0] data_mem [16][2];
  logic         lru      [16];
  logic         arr_clr;
  int           arr_writes;
  logic [24:0]  last_wr_tag;
  logic [255:0] last_wr_data;
  logic [3:0]   a_idx;
  logic [22:0]  a_tag;
  logic         a_hit;
  logic         a_way;

  always_comb begin
    a_idx = bus.sram_index_o;
    a_tag = bus.sram_tag_o[22:0];
    a_hit = 1'b0;
    a_way = lru[a_idx];
    for (int w = 0; w < 2; w++) begin
      if (tag_mem[a_idx][w][24] && tag_mem[a_idx][w][22:0] == a_tag) begin
        a_hit = 1'b1;
        a_way = 1'(w);
      end
    end
    bus.sram_hit_i  = a_hit & bus.sram_enable_o;
    bus.sram_tag_i  = tag_mem[a_idx][a_way];
    bus.sram_data_i = data_mem[a_idx][a_way];
  end

  always @(posedge clk) begin
    if (arr_clr) begin
      for (int s = 0; s < 16; s++) begin
        for (int w = 0; w < 2; w++) begin
          tag_mem[s][w]  <= '0;
          data_mem[s][w] <= '0;
        end
        lru[s] <= 1'b0;
      end
      arr_writes   <= 0;
      last_wr_tag  <= '0;
      last_wr_data <= '0;
    end else if (bus.sram_enable_o) begin
      if (bus.sram_write_o) begin
        tag_mem[a_idx][a_way]  <= bus.sram_tag_o;
        data_mem[a_idx][a_way] <= bus.sram_data_o;
        lru[a_idx]             <= ~a_way;
        arr_writes             <= arr_writes + 1;
        last_wr_tag            <= bus.sram_tag_o;
        last_wr_data           <= bus.sram_data_o;
      end else if (a_hit) begin
        lru[a_idx] <= ~a_way;
      end
    end
  end

  // ---------------- memory and reference ----------------
  logic [255:0] mem_lines [logic [26:0]];
  logic [31:0]  ref_words [logic [29:0]];

  function automatic logic [31:0] init_word(input logic [29:0] wa);
    return (32'(wa) * 32'h9E37_79B1) ^ 32'h3C5A_0F96;
  endfunction

  function automatic logic [255:0] mem_read(input logic [26:0] la);
    logic [255:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = init_word({la, 3'(k)});
    return l;
  endfunction

  function automatic logic [31:0] ref_read(input logic [29:0] wa);
    if (ref_words.exists(wa)) return ref_words[wa];
    return init_word(wa);
  endfunction

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } txn_t;
  txn_t txq[$];

  int   lat = 10;
  int   resp_cnt = -1;
  logic resp_ack = 1'b0;
  logic spur_ack = 1'b0;
  txn_t pend;

  assign bus.mem_ack_i = resp_ack | spur_ack;

  // Memory responder: ack arrives lat cycles after a request is first seen
  initial begin
    bus.mem_data_i = '0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
      end else if (resp_cnt == 0) begin
        resp_ack = 1'b1;
        resp_cnt = -1;
        if (pend.wr) mem_lines[pend.addr[31:5]] = pend.data;
        else bus.mem_data_i = mem_read(pend.addr[31:5]);
      end else if (bus.mem_enable_o && !rst) begin
        pend.addr = bus.mem_addr_o;
        pend.wr   = bus.mem_write_o;
        pend.data = bus.mem_data_o;
        txq.push_back(pend);
        resp_cnt = lat - 1;
      end
    end
  end

  // ---------------- CPU side ----------------
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic both, output logic [31:0] rd, output int cyc);
    bit done;
    done = 0;
    bus.cpu_addr_i     = a;
    bus.cpu_data_i     = d;
    bus.cpu_MemWrite_i = w;
    bus.cpu_MemRead_i  = ~w | both;
    cyc = 0;
    rd  = '0;
    while (!done) begin
      @(negedge clk);
      if (!bus.cpu_stall_o) begin
        rd   = bus.cpu_data_o;
        done = 1;
      end else begin
        cyc++;
        if (cyc > 400) begin
          check("access_timeout", 256'(cyc), 0);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
  endtask

  // Access plus reference bookkeeping: loads must match the flat memory
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] d,
                    input logic w, input logic both, output int cyc);
    logic [31:0] rd;
    access(a, d, w, both, rd, cyc);
    if (w) ref_words[a[31:2]] = d;
    else check(tag, rd, ref_read(a[31:2]));
  endtask

  initial begin
    int          cyc;
    int          n0;
    int          w0;
    int          k;
    logic [255:0] l;
    logic [31:0] ra;

    bus.cpu_addr_i     = '0;
    bus.cpu_data_i     = '0;
    bus.cpu_MemRead_i  = 1'b0;
    bus.cpu_MemWrite_i = 1'b0;
    arr_clr = 1'b1;

    l = mem_read(27'h9);
    l[31:0] = 32'h1111_1111;
    mem_lines[27'h9] = l;
    ref_words[30'h48] = 32'h1111_1111;

    repeat (3) @(posedge clk);
    #1;
    arr_clr = 1'b0;
    @(negedge clk);
    check("rst_stall",      bus.cpu_stall_o,   0);
    check("rst_mem_en",     bus.mem_enable_o,  0);
    check("rst_mem_wr",     bus.mem_write_o,   0);
    check("rst_mem_addr",   bus.mem_addr_o,    0);
    check("rst_sram_en",    bus.sram_enable_o, 0);
    check("rst_sram_wr",    bus.sram_write_o,  0);
    check("rst_sram_tag",   bus.sram_tag_o,    0);
    check("rst_cpu_data",   bus.cpu_data_o,    bus.sram_data_i[31:0]);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold load: one read at the line address, refill written clean
    txq.delete();
    op("cold_load", 32'h0000_0120, 0, 0, 0, cyc);
    check("cold_txn_cnt",  txq.size(), 1);
    check("cold_txn_wr",   txq[0].wr, 0);
    check("cold_txn_addr", txq[0].addr, 32'h0000_0120);
    check("cold_fill_tag", last_wr_tag, {2'b10, 23'h0});
    // Stalled: IDLE miss cycle, MISS, lat+1 READMISS cycles
    // (enable cycle through ack cycle), READMISSOK
    check("cold_stall_cyc", 256'(cyc), 256'(lat + 4));

    // Store hit: no stall, word1 merged, entry marked dirty
    w0 = arr_writes;
    op("store_hit", 32'h0000_0124, 32'hDEAD_BEEF, 1, 0, cyc);
    check("store_stall",  256'(cyc), 0);
    check("store_writes", 256'(arr_writes), 256'(w0 + 1));
    check("store_tag",    last_wr_tag, {2'b11, 23'h0});
    check("store_word1",  last_wr_data[63:32], 32'hDEAD_BEEF);
    check("store_word0",  last_wr_data[31:0], 32'h1111_1111);
    op("load_after_store", 32'h0000_0124, 0, 0, 0, cyc);
    check("load_after_store_stall", 256'(cyc), 0);

    // Second line in set 9 fills the empty way; no write-back
    lat = 4;
    txq.delete();
    op("load_320", 32'h0000_0320, 0, 0, 0, cyc);
    check("load_320_txn_cnt", txq.size(), 1);

    // Dirty eviction of 0x120 followed by refill of 0x520
    txq.delete();
    op("dirty_evict_load", 32'h0000_0520, 0, 0, 0, cyc);
    check("evict_txn_cnt",   txq.size(), 2);
    check("evict_wb_wr",     txq[0].wr, 1);
    check("evict_wb_addr",   txq[0].addr, 32'h0000_0120);
    check("evict_wb_word1",  txq[0].data[63:32], 32'hDEAD_BEEF);
    check("evict_wb_word0",  txq[0].data[31:0], 32'h1111_1111);
    check("evict_rd_wr",     txq[1].wr, 0);
    check("evict_rd_addr",   txq[1].addr, 32'h0000_0520);
    check("evict_fill_tag",  last_wr_tag, {2'b10, 23'h2});
    op("reload_124", 32'h0000_0124, 0, 0, 0, cyc);

    // Clean eviction: the only memory transaction is a read
    txq.delete();
    op("clean_evict_load", 32'h0000_0720, 0, 0, 0, cyc);
    check("clean_txn_cnt",  txq.size(), 1);
    check("clean_txn_wr",   txq[0].wr, 0);
    check("clean_txn_addr", txq[0].addr, 32'h0000_0720);

    // Spurious ack while idle with no request
    w0 = arr_writes;
    spur_ack = 1'b1;
    @(negedge clk);
    check("spur_sram_en", bus.sram_enable_o, 0);
    check("spur_stall",   bus.cpu_stall_o, 0);
    @(posedge clk);
    #1;
    spur_ack = 1'b0;
    @(negedge clk);
    check("spur_mem_en",  bus.mem_enable_o, 0);
    check("spur_stall2",  bus.cpu_stall_o, 0);
    check("spur_writes",  256'(arr_writes), 256'(w0));
    @(posedge clk);
    #1;
    op("spur_hit", 32'h0000_0720, 0, 0, 0, cyc);
    check("spur_hit_stall", 256'(cyc), 0);

    // Reset during READMISS before the ack
    lat = 10;
    n0 = txq.size();
    bus.cpu_addr_i    = 32'h0000_0A40;
    bus.cpu_MemRead_i = 1'b1;
    k = 0;
    while (txq.size() == n0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_req_seen", txq.size(), n0 + 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cpu_MemRead_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_en",  bus.mem_enable_o, 0);
    check("rst_mid_stall",   bus.cpu_stall_o, 0);
    check("rst_mid_sram_en", bus.sram_enable_o, 0);
    w0 = arr_writes;
    repeat (15) @(negedge clk);
    check("rst_late_ack_done", 256'(resp_cnt + 1), 0);
    check("rst_late_writes",   256'(arr_writes), 256'(w0));
    check("rst_late_txn_cnt",  txq.size(), n0 + 1);
    @(posedge clk);
    #1;

    // Randomized loads/stores over a few conflicting sets
    for (int i = 0; i < 300; i++) begin
      logic w;
      logic both;
      lat  = $urandom_range(1, 6);
      ra   = {23'($urandom_range(0, 4)), 4'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), 2'b00};
      w    = 1'($urandom_range(0, 1));
      both = w & 1'($urandom_range(0, 1));
      op("rand_load", ra, $urandom, w, both, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
